// File: rtl/instr_fetch.sv
// Instruction fetch stage: latches the PC, runs one req/ack bus read per
// instruction, and hands the fetched word to decode over valid/ready.
// Also drives the PC's increment pulse and hold (disable) inputs, handles
// branch flush and bus timeout. Every output is a register.
//
// Handshakes:
//   bus    : mem_req rises and then stays high until a cycle with mem_ack=1.
//            It is never withdrawn early, even on flush. mem_ack may already
//            be high in the first mem_req cycle.
//   decode : a transfer occurs on a posedge where instr_valid=1 and
//            decode_ready=1 and flush=0. instr is stable while instr_valid=1.
module instr_fetch #(
  parameter int          TIMEOUT     = 16,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc_val,
  input  logic        flush,
  input  logic        decode_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        pc_inc,
  output logic        pc_hold,
  output logic        fetch_err,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_q;
  logic [CW-1:0] count_q;

  // FSM state is visible for debug and assertion binding.
  assign state_dbg = state_q;

  // Main fetch FSM. mem_addr doubles as the latched PC: it is loaded only in
  // IDLE, so it stays fixed through FETCH/DRAIN even if pc_val moves.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= 32'd0;
      instr       <= RESET_INSTR;
      instr_valid <= 1'b0;
      pc_inc      <= 1'b0;
      pc_hold     <= 1'b1;
      fetch_err   <= 1'b0;
    end else begin
      // The PC increment is a single-cycle pulse.
      pc_inc <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_addr <= pc_val;
          count_q  <= '0;
          mem_req  <= 1'b1;
          pc_hold  <= 1'b1;
          state_q  <= FETCH;
        end

        FETCH: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            pc_hold <= 1'b0;
            if (!flush) begin
              instr       <= mem_rdata;
              instr_valid <= 1'b1;
              pc_inc      <= 1'b1;
              state_q     <= HOLD;
            end else begin
              // The response belongs to the flushed path: drop it.
              state_q <= IDLE;
            end
          end else if (count_q == CNT_LAST) begin
            // The timeout wins over a flush that arrives on the same cycle.
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            pc_hold   <= 1'b1;
            state_q   <= ERR;
          end else begin
            count_q <= count_q + 1'b1;
            // The request cannot be withdrawn, so wait out the ack in DRAIN.
            if (flush) state_q <= DRAIN;
          end
        end

        HOLD: begin
          if (flush) begin
            instr_valid <= 1'b0;
            instr       <= RESET_INSTR;
            state_q     <= IDLE;
          end else if (decode_ready) begin
            instr_valid <= 1'b0;
            state_q     <= IDLE;
          end
        end

        DRAIN: begin
          // Further flushes are irrelevant here; the data is dropped anyway.
          if (mem_ack) begin
            mem_req <= 1'b0;
            pc_hold <= 1'b0;
            state_q <= IDLE;
          end else if (count_q == CNT_LAST) begin
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            pc_hold   <= 1'b1;
            state_q   <= ERR;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end

        ERR: begin
          // Terminal until clr.
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
          pc_hold     <= 1'b1;
          fetch_err   <= 1'b1;
        end

        default: begin
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: scenario tasks driving the bus and decode side,
// with a scoreboard of expected instructions consumed at decode transfers.
module tb_instr_fetch;

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_FETCH = 3'd1;
  localparam logic [2:0]  S_HOLD  = 3'd2;
  localparam logic [2:0]  S_DRAIN = 3'd3;
  localparam logic [2:0]  S_ERR   = 3'd4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] pc_val = 32'd0;
  logic        flush = 1'b0;
  logic        decode_ready = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        pc_inc;
  logic        pc_hold;
  logic        fetch_err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int pc_inc_cnt = 0;
  int req_cnt = 0;
  bit valid_seen = 1'b0;
  logic [31:0] exp_q[$];

  instr_fetch #(.TIMEOUT(16), .RESET_INSTR(NOP)) dut (
    .clk(clk), .clr(clr), .pc_val(pc_val), .flush(flush),
    .decode_ready(decode_ready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc_inc(pc_inc), .pc_hold(pc_hold),
    .fetch_err(fetch_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Advance one edge; outputs are then settled and inputs may be changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: a decode transfer pops one expected word; also counts events
  always @(negedge clk) begin
    if (!clr && instr_valid && decode_ready && !flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: instr=%h delivered, no word expected", instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (instr !== e) begin
          errors++;
          $display("FAIL sb_instr: got %h expected %h", instr, e);
        end
      end
    end
    if (pc_inc) pc_inc_cnt++;
    if (mem_req) req_cnt++;
    if (instr_valid) valid_seen = 1'b1;
  end

  task automatic test_reset();
    clr = 1'b1; pc_val = 32'd0; decode_ready = 1'b1;
    step(); step();
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, S_IDLE); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h expected %h", instr, NOP); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL rst_pc_inc: got %b expected 0", pc_inc); end
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL rst_pc_hold: got %b expected 1", pc_hold); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_fetch_err: got %b expected 0", fetch_err); end
    clr = 1'b0;
  endtask

  // Immediate ack, decode ready: IDLE, FETCH, HOLD.
  task automatic test_basic();
    int inc0;
    inc0 = pc_inc_cnt;
    step(); // IDLE -> FETCH
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin errors++; $display("FAIL basic_req: req=%b addr=%h expected 1/0", mem_req, mem_addr); end
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_fetch: got %b expected 1", pc_hold); end
    exp_q.push_back(32'h0050_0093);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    step(); // FETCH -> HOLD
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc_inc !== 1'b1) begin errors++; $display("FAIL basic_valid: valid=%b pc_inc=%b expected 1/1", instr_valid, pc_inc); end
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr: got %h expected 00500093", instr); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %b expected 0", mem_req); end
    step(); // HOLD -> IDLE
    checks++; if (state_dbg !== S_IDLE || instr_valid !== 1'b0 || pc_inc !== 1'b0) begin errors++; $display("FAIL basic_back_idle: state=%0d valid=%b pc_inc=%b expected 0/0/0", state_dbg, instr_valid, pc_inc); end
    checks++; if (pc_inc_cnt - inc0 != 1) begin errors++; $display("FAIL basic_inc_count: got %0d expected 1", pc_inc_cnt - inc0); end
  endtask

  // Three wait cycles before ack; pc_val moves mid-fetch.
  task automatic test_wait_states();
    int inc0;
    int req0;
    inc0 = pc_inc_cnt; req0 = req_cnt;
    pc_val = 32'h40; decode_ready = 1'b1;
    step(); // -> FETCH
    pc_val = 32'h0000_0099;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL wait_addr[%0d]: req=%b addr=%h expected 1/40", i, mem_req, mem_addr); end
      step();
    end
    exp_q.push_back(32'hA5A5_0001);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    step();
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'hA5A5_0001) begin errors++; $display("FAIL wait_instr: valid=%b instr=%h expected 1/a5a50001", instr_valid, instr); end
    step(); // HOLD -> IDLE
    checks++; if (req_cnt - req0 != 4) begin errors++; $display("FAIL wait_req_cycles: got %0d expected 4", req_cnt - req0); end
    checks++; if (pc_inc_cnt - inc0 != 1) begin errors++; $display("FAIL wait_inc_count: got %0d expected 1", pc_inc_cnt - inc0); end
  endtask

  // Decode stalls five cycles in HOLD.
  task automatic test_hold_stall();
    int inc0;
    inc0 = pc_inc_cnt;
    pc_val = 32'h80; decode_ready = 1'b0;
    step(); // -> FETCH
    exp_q.push_back(32'h1234_5678);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step(); // -> HOLD
    mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr !== 32'h1234_5678 || instr_valid !== 1'b1 || pc_hold !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: instr=%h valid=%b pc_hold=%b expected 12345678/1/0", i, instr, instr_valid, pc_hold); end
      step();
    end
    checks++; if (pc_inc_cnt - inc0 != 1) begin errors++; $display("FAIL stall_inc_count: got %0d expected 1", pc_inc_cnt - inc0); end
    decode_ready = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b0 || state_dbg !== S_IDLE) begin errors++; $display("FAIL stall_release: valid=%b state=%0d expected 0/0", instr_valid, state_dbg); end
  endtask

  // Flush in the 2nd FETCH cycle, ack two cycles later is dropped.
  task automatic test_flush_drain();
    int inc0;
    inc0 = pc_inc_cnt; valid_seen = 1'b0;
    pc_val = 32'hC0; decode_ready = 1'b1;
    step(); // -> FETCH (1st cycle)
    step(); // 2nd FETCH cycle
    flush = 1'b1;
    step(); // -> DRAIN
    flush = 1'b0;
    checks++; if (state_dbg !== S_DRAIN || mem_req !== 1'b1 || pc_hold !== 1'b1 || mem_addr !== 32'hC0) begin errors++; $display("FAIL drain_enter: state=%0d req=%b hold=%b addr=%h expected 3/1/1/c0", state_dbg, mem_req, pc_hold, mem_addr); end
    flush = 1'b1; // ignored in DRAIN
    step();
    flush = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step(); // -> IDLE
    mem_ack = 1'b0;
    checks++; if (state_dbg !== S_IDLE || mem_req !== 1'b0) begin errors++; $display("FAIL drain_exit: state=%0d req=%b expected 0/0", state_dbg, mem_req); end
    checks++; if (instr !== 32'h1234_5678 || valid_seen) begin errors++; $display("FAIL drain_instr: instr=%h valid_seen=%b expected 12345678/0", instr, valid_seen); end
    checks++; if (pc_inc_cnt != inc0) begin errors++; $display("FAIL drain_no_inc: got %0d pulses expected 0", pc_inc_cnt - inc0); end
    pc_val = 32'h100;
    step(); // -> FETCH at new PC
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL drain_next_addr: got %h expected 100", mem_addr); end
    exp_q.push_back(32'h0000_1111);
    mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
    step();
    mem_ack = 1'b0;
    step();
  endtask

  // flush and ack in the same FETCH cycle.
  task automatic test_flush_ack();
    int inc0;
    inc0 = pc_inc_cnt; valid_seen = 1'b0;
    pc_val = 32'h200;
    step(); // -> FETCH
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step();
    flush = 1'b0; mem_ack = 1'b0;
    checks++; if (state_dbg !== S_IDLE || instr_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL flush_ack: state=%0d valid=%b req=%b expected 0/0/0", state_dbg, instr_valid, mem_req); end
    checks++; if (pc_inc_cnt != inc0 || valid_seen) begin errors++; $display("FAIL flush_ack_inc: pulses=%0d valid_seen=%b expected 0/0", pc_inc_cnt - inc0, valid_seen); end
  endtask

  // flush in HOLD beats decode_ready and restores the NOP.
  task automatic test_hold_flush();
    pc_val = 32'h240; decode_ready = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    step(); // -> HOLD (word will be flushed, nothing pushed)
    mem_ack = 1'b0;
    flush = 1'b1; decode_ready = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (instr !== NOP || instr_valid !== 1'b0 || state_dbg !== S_IDLE) begin errors++; $display("FAIL hold_flush: instr=%h valid=%b state=%0d expected %h/0/0", instr, instr_valid, state_dbg, NOP); end
  endtask

  // clr during FETCH, then a late ack in IDLE is ignored.
  task automatic test_clr_midfetch();
    pc_val = 32'h280;
    step(); // -> FETCH
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (mem_req !== 1'b0 || state_dbg !== S_IDLE) begin errors++; $display("FAIL clr_mid: req=%b state=%0d expected 0/0", mem_req, state_dbg); end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    step(); // IDLE ignores ack -> FETCH
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || state_dbg !== S_FETCH || mem_addr !== 32'h280) begin errors++; $display("FAIL clr_late_ack: valid=%b state=%0d addr=%h expected 0/1/280", instr_valid, state_dbg, mem_addr); end
    exp_q.push_back(32'h6666_6666);
    mem_ack = 1'b1; mem_rdata = 32'h6666_6666;
    step();
    mem_ack = 1'b0;
    step();
  endtask

  // 16 FETCH cycles without ack -> ERR until clr.
  task automatic test_timeout();
    pc_val = 32'h300;
    step(); // -> FETCH, count 0
    for (int i = 0; i < 15; i++) step();
    checks++; if (fetch_err !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL timeout_early: err=%b req=%b expected 0/1", fetch_err, mem_req); end
    step();
    checks++; if (fetch_err !== 1'b1 || mem_req !== 1'b0 || pc_hold !== 1'b1 || instr_valid !== 1'b0 || state_dbg !== S_ERR) begin errors++; $display("FAIL timeout_err: err=%b req=%b hold=%b valid=%b state=%0d expected 1/0/1/0/4", fetch_err, mem_req, pc_hold, instr_valid, state_dbg); end
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom; flush = 1'($urandom_range(0, 1));
      step();
    end
    mem_ack = 1'b0; flush = 1'b0;
    checks++; if (fetch_err !== 1'b1 || state_dbg !== S_ERR || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_sticky: err=%b state=%0d req=%b expected 1/4/0", fetch_err, state_dbg, mem_req); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (fetch_err !== 1'b0 || state_dbg !== S_IDLE || instr !== NOP || pc_hold !== 1'b1 || mem_addr !== 32'd0) begin errors++; $display("FAIL timeout_clr: err=%b state=%0d instr=%h hold=%b addr=%h expected 0/0/%h/1/0", fetch_err, state_dbg, instr, pc_hold, mem_addr, NOP); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_hold_stall();
    test_flush_drain();
    test_flush_ack();
    test_hold_flush();
    test_clr_midfetch();
    test_timeout();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d words left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
